fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single outstanding memory
// request and an F/D pipeline register. A redirect always wins: it flushes
// F/D, reloads the PC and, if a request is still in flight, arranges for
// its response to be thrown away.
// Optional macro FETCH_MISALIGN_CHECK_EN: reject redirects whose target is
// not word aligned and report them on misalign_err. Without it, redirect
// targets are forced to word alignment.
module fetch_unit #(
    parameter int unsigned       N_BITS   = 32,
    parameter logic [N_BITS-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [N_BITS-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [N_BITS-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [N_BITS-1:0] redirect_pc,
    output logic              fd_valid,
    input  logic              fd_ready,
    output logic [N_BITS-1:0] fd_pc,
    output logic [N_BITS-1:0] fd_pc_plus_4,
    output logic [N_BITS-1:0] fd_instr
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic              misalign_err
`endif
);

    // S_REQ: may issue; S_WAIT: request in flight; S_DROP: in-flight
    // response belongs to a flushed path and must be discarded.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              run_q;
    logic [N_BITS-1:0] pc_q;
    logic [N_BITS-1:0] pc_plus_4;
    logic              req_fire;
    logic              rsp_load;
    logic              redirect_take;
    logic [N_BITS-1:0] redirect_target;

    assign pc_plus_4     = pc_q + N_BITS'(4);
    assign imem_req_addr = pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic redirect_misaligned;

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_take       = redirect_valid && !redirect_misaligned;
    assign redirect_target     = redirect_pc;

    // One-cycle error pulse for every rejected (misaligned) redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_misaligned;
        end
    end
`else
    assign redirect_take   = redirect_valid;
    assign redirect_target = redirect_pc & ~N_BITS'(3);
`endif

    // State register; run_q holds off the first request until one clock
    // edge after reset release so nothing is requested while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            run_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state and request handshake; redirect is evaluated first.
    always_comb begin
        // NOTE: every output of this block gets a default here so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        rsp_load       = 1'b0;
        unique case (state_q)
            S_REQ: begin
                // Issue only when the F/D slot is empty or drains this cycle.
                imem_req_valid = run_q && (!fd_valid || fd_ready);
                req_fire       = imem_req_valid && imem_req_ready;
                if (redirect_take) begin
                    state_d = req_fire ? S_DROP : S_REQ;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_take) begin
                    state_d = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    rsp_load = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Program counter: redirect target, else sequential advance on a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_take) begin
            pc_q <= redirect_target;
        end else if (rsp_load) begin
            pc_q <= pc_plus_4;
        end
    end

    // F/D register: flush on redirect, fill on response, drain on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_valid     <= 1'b0;
            fd_pc        <= '0;
            fd_pc_plus_4 <= '0;
            fd_instr     <= '0;
        end else if (redirect_take) begin
            fd_valid <= 1'b0;
        end else if (rsp_load) begin
            fd_valid     <= 1'b1;
            fd_pc        <= pc_q;
            fd_pc_plus_4 <= pc_plus_4;
            fd_instr     <= imem_rsp_data;
        end else if (fd_ready) begin
            fd_valid <= 1'b0;
        end
    end

endmodule
